// File: rtl/mdio_slave_22_45_frontend.sv
// rtl/mdio_slave_22_45_frontend.sv - MDIO slave frontend: preamble hunt, frame capture, read data drive
module mdio_slave_22_45_frontend #(
    parameter int PRE_LEN     = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk_25m,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_in,
    input  logic [4:0]  phy_addr,
    input  logic [15:0] resp_rdata,
    input  logic        resp_ready,
    output logic [31:0] rx_data,
    output logic        phyaddr_done_pos,
    output logic        info_done_pos,
    output logic        data_done_pos,
    output logic        legal,
    output logic        time_out_flag,
    output logic        mdio_out,
    output logic        mdio_oe
);
    localparam int              TW      = $clog2(TIMEOUT_CYC);
    localparam logic [5:0]      PRE_MIN = 6'(PRE_LEN);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, FRAME} state_t;
    state_t state_q, state_d;

    logic [2:0]    mdc_sync;
    logic [1:0]    mdio_sync;
    logic          rise;
    logic          sample;
    logic [5:0]    pre_cnt;
    logic [5:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic          is_rd;
    logic          rsp_wait;
    logic [15:0]   rsp_sr;
    logic          frame_start;
    logic          timeout_hit;

    assign rise   = mdc_sync[1] & ~mdc_sync[2];
    assign sample = mdio_sync[1];

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        timeout_hit = 1'b0;
        if (state_q == IDLE) begin
            if (rise && !sample && (pre_cnt >= PRE_MIN)) begin
                frame_start = 1'b1;
                state_d     = FRAME;
            end
        end else begin
            // A stall abort wins over an MDC edge arriving in the same cycle
            if (to_cnt == TO_LAST) begin
                timeout_hit = 1'b1;
                state_d     = IDLE;
            end else if (rise && (bit_cnt == 6'd31)) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            mdc_sync         <= 3'b000;
            mdio_sync        <= 2'b00;
            pre_cnt          <= 6'd0;
            bit_cnt          <= 6'd0;
            to_cnt           <= '0;
            is_rd            <= 1'b0;
            rsp_wait         <= 1'b0;
            rsp_sr           <= 16'h0000;
            rx_data          <= 32'h0;
            phyaddr_done_pos <= 1'b0;
            info_done_pos    <= 1'b0;
            data_done_pos    <= 1'b0;
            legal            <= 1'b0;
            time_out_flag    <= 1'b0;
            mdio_out         <= 1'b0;
            mdio_oe          <= 1'b0;
        end else begin
            mdc_sync         <= {mdc_sync[1:0], mdc};
            mdio_sync        <= {mdio_sync[0], mdio_in};
            phyaddr_done_pos <= 1'b0;
            info_done_pos    <= 1'b0;
            data_done_pos    <= 1'b0;
            time_out_flag    <= 1'b0;
            if (state_q == IDLE) begin
                legal    <= 1'b0;
                to_cnt   <= '0;
                is_rd    <= 1'b0;
                rsp_wait <= 1'b0;
                mdio_oe  <= 1'b0;
                mdio_out <= 1'b0;
                if (rise) begin
                    pre_cnt <= !sample ? 6'd0 : (pre_cnt == 6'd63) ? 6'd63 : pre_cnt + 6'd1;
                    if (frame_start) begin
                        rx_data <= 32'h0;
                        bit_cnt <= 6'd1;
                    end
                end
            end else if (timeout_hit) begin
                time_out_flag <= 1'b1;
                mdio_oe       <= 1'b0;
                mdio_out      <= 1'b0;
                legal         <= 1'b0;
                pre_cnt       <= 6'd0;
                bit_cnt       <= 6'd0;
                to_cnt        <= '0;
                rsp_wait      <= 1'b0;
            end else begin
                pre_cnt <= 6'd0;
                if (rsp_wait && resp_ready) begin
                    rsp_sr   <= resp_rdata;
                    rsp_wait <= 1'b0;
                end
                if (rise) begin
                    to_cnt  <= '0;
                    bit_cnt <= bit_cnt + 6'd1;
                    // Read data phase belongs to this PHY, never to the sampled line
                    if (!(is_rd && (bit_cnt >= 6'd16))) begin
                        rx_data[5'd31 - bit_cnt[4:0]] <= sample;
                    end
                    case (bit_cnt)
                        6'd8: begin
                            phyaddr_done_pos <= 1'b1;
                            legal            <= ({rx_data[27:24], sample} == phy_addr);
                        end
                        6'd13: begin
                            info_done_pos <= 1'b1;
                            is_rd         <= rx_data[29];
                            rsp_sr        <= 16'h0000;
                            rsp_wait      <= 1'b1;
                        end
                        6'd14: begin
                            if (is_rd && legal) begin
                                mdio_oe  <= 1'b1;
                                mdio_out <= 1'b0;
                                rsp_wait <= 1'b0;
                            end
                        end
                        6'd31: begin
                            mdio_oe       <= 1'b0;
                            mdio_out      <= 1'b0;
                            data_done_pos <= ~is_rd;
                            bit_cnt       <= 6'd0;
                        end
                        default: begin
                            if ((bit_cnt >= 6'd15) && mdio_oe) begin
                                mdio_out <= rsp_sr[15];
                                rsp_sr   <= {rsp_sr[14:0], 1'b0};
                            end
                        end
                    endcase
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end
        end
    end
endmodule
